// File: rtl/coef_bank_ctrl_if.sv
// Coefficient write port of the FIR coefficient bank controller:
// write strobe, entry index, complex value and the early-commit request.
interface coef_bank_ctrl_if #(
  parameter int CW = 27
);
  logic          PushCoef;
  logic [4:0]    CoefAddr;
  logic [CW-1:0] CoefI;
  logic [CW-1:0] CoefQ;
  logic          CoefCommit;

  modport master (output PushCoef, CoefAddr, CoefI, CoefQ, CoefCommit);
  modport slave  (input  PushCoef, CoefAddr, CoefI, CoefQ, CoefCommit);
endinterface

// File: rtl/coef_bank_ctrl.sv
// Double-buffered coefficient bank: writes land in a shadow bank, and the whole
// bank is copied to the active bank only at an idle computation boundary.
module coef_bank_ctrl #(
  parameter int NCOEF = 15,
  parameter int CW    = 27,
  parameter int VW    = 8
) (
  input  logic                  clk,
  input  logic                  Reset,
  coef_bank_ctrl_if.slave       wr,
  input  logic                  mult_idle,
  input  logic                  calc_start,
  output logic [NCOEF*2*CW-1:0] coef_active,
  output logic                  hold_start,
  output logic                  coef_pending,
  output logic                  coef_swap,
  output logic [VW-1:0]         coef_version,
  output logic                  coef_addr_err
);
  localparam int         EW      = 2 * CW;
  localparam logic [4:0] NCOEF_A = 5'(NCOEF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;
  logic [EW-1:0]        shadow_r [NCOEF];
  logic [NCOEF*EW-1:0]  active_r;
  logic [NCOEF-1:0]     wr_mask_r;
  logic [NCOEF-1:0]     mask_set_s;
  logic [NCOEF-1:0]     mask_nxt_s;
  logic [VW-1:0]        version_r;
  logic                 swap_r;
  logic                 addr_err_r;
  logic                 hold_r;
  logic                 pending_r;
  logic                 addr_ok_s;
  logic                 wr_ok_s;
  logic                 swap_go_s;

  // Write decode, swap qualification and next mask/state selection.
  always_comb begin
    addr_ok_s   = (wr.CoefAddr < NCOEF_A);
    wr_ok_s     = wr.PushCoef & addr_ok_s;
    swap_go_s   = (state_r == READY) & mult_idle & ~calc_start;
    mask_set_s  = '0;
    for (int k = 0; k < NCOEF; k++) begin
      mask_set_s[k] = wr_ok_s & (wr.CoefAddr == 5'(k));
    end
    // A write on the swap edge belongs to the next bank, so it starts a fresh mask.
    if (swap_go_s) begin
      mask_nxt_s = mask_set_s;
    end else begin
      mask_nxt_s = wr_mask_r | mask_set_s;
    end
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (wr_ok_s) begin
          state_nxt_s = (&mask_nxt_s) ? READY : LOAD;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOAD: begin
        if ((&mask_nxt_s) || wr.CoefCommit) begin
          state_nxt_s = READY;
        end else begin
          state_nxt_s = LOAD;
        end
      end
      READY: begin
        if (swap_go_s) begin
          state_nxt_s = wr_ok_s ? LOAD : IDLE;
        end else begin
          state_nxt_s = READY;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Bank storage, control state and registered status outputs.
  always_ff @(posedge clk) begin
    if (Reset) begin
      for (int k = 0; k < NCOEF; k++) begin
        shadow_r[k] <= '0;
      end
      active_r   <= '0;
      wr_mask_r  <= '0;
      state_r    <= IDLE;
      version_r  <= '0;
      swap_r     <= 1'b0;
      addr_err_r <= 1'b0;
      hold_r     <= 1'b0;
      pending_r  <= 1'b0;
    end else begin
      // The copy reads the pre-edge shadow, so a same-edge write is not included.
      if (swap_go_s) begin
        for (int k = 0; k < NCOEF; k++) begin
          active_r[k*EW +: EW] <= shadow_r[k];
        end
        version_r <= version_r + VW'(1);
      end
      for (int k = 0; k < NCOEF; k++) begin
        if (mask_set_s[k]) begin
          shadow_r[k] <= {wr.CoefI, wr.CoefQ};
        end
      end
      wr_mask_r  <= mask_nxt_s;
      state_r    <= state_nxt_s;
      swap_r     <= swap_go_s;
      addr_err_r <= wr.PushCoef & ~addr_ok_s;
      hold_r     <= (state_nxt_s == READY);
      pending_r  <= (state_nxt_s != IDLE);
    end
  end

  assign coef_active   = active_r;
  assign hold_start    = hold_r;
  assign coef_pending  = pending_r;
  assign coef_swap     = swap_r;
  assign coef_version  = version_r;
  assign coef_addr_err = addr_err_r;

endmodule

// File: tb/tb_coef_bank_ctrl.sv
// Directed bench for coef_bank_ctrl: a vector table for the full load and
// address errors, then hand sequences for deferral, commit, same-edge write, wrap, reset.
module tb_coef_bank_ctrl;
  localparam int NCOEF = 15;
  localparam int CW    = 27;
  localparam int VW    = 8;
  localparam int EW    = 2 * CW;

  logic                  clk = 1'b0;
  logic                  Reset = 1'b1;
  logic                  mult_idle = 1'b1;
  logic                  calc_start = 1'b0;
  logic [NCOEF*EW-1:0]   coef_active;
  logic                  hold_start;
  logic                  coef_pending;
  logic                  coef_swap;
  logic [VW-1:0]         coef_version;
  logic                  coef_addr_err;

  coef_bank_ctrl_if #(.CW(CW)) bus ();

  coef_bank_ctrl #(.NCOEF(NCOEF), .CW(CW), .VW(VW)) dut (
    .clk           (clk),
    .Reset         (Reset),
    .wr            (bus),
    .mult_idle     (mult_idle),
    .calc_start    (calc_start),
    .coef_active   (coef_active),
    .hold_start    (hold_start),
    .coef_pending  (coef_pending),
    .coef_swap     (coef_swap),
    .coef_version  (coef_version),
    .coef_addr_err (coef_addr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          push;
    logic [4:0]    addr;
    logic [CW-1:0] ci;
    logic [CW-1:0] cq;
    logic          commit;
    logic          idle;
    logic          cs;
    logic          e_hold;
    logic          e_pend;
    logic          e_swap;
    logic          e_err;
    logic [VW-1:0] e_ver;
  } vec_t;

  vec_t          tbl [20];
  logic [EW-1:0] exp_act [NCOEF];
  int            checks = 0;
  int            errors = 0;

  function automatic logic [CW-1:0] cv(input int v);
    return CW'(v);
  endfunction

  function automatic logic [EW-1:0] ent(input int k);
    return coef_active[k*EW +: EW];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_bank(input string name);
    int bad;
    bad = -1;
    for (int k = NCOEF - 1; k >= 0; k--) begin
      if (ent(k) !== exp_act[k]) bad = k;
    end
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s: active entry %0d got %0h expected %0h", name, bad, ent(bad), exp_act[bad]);
    end
  endtask

  task automatic chk_out(input string name, input logic hold, input logic pend,
                         input logic swp, input logic err, input logic [VW-1:0] ver);
    chk({name, "_hold"},  64'(hold_start),    64'(hold));
    chk({name, "_pend"},  64'(coef_pending),  64'(pend));
    chk({name, "_swap"},  64'(coef_swap),     64'(swp));
    chk({name, "_err"},   64'(coef_addr_err), 64'(err));
    chk({name, "_ver"},   64'(coef_version),  64'(ver));
  endtask

  task automatic cyc(input logic push, input logic [4:0] addr, input logic [CW-1:0] ci,
                     input logic [CW-1:0] cq, input logic commit, input logic idle, input logic cs);
    bus.PushCoef   = push;
    bus.CoefAddr   = addr;
    bus.CoefI      = ci;
    bus.CoefQ      = cq;
    bus.CoefCommit = commit;
    mult_idle      = idle;
    calc_start     = cs;
    @(posedge clk);
    #1;
    bus.PushCoef   = 1'b0;
    bus.CoefCommit = 1'b0;
  endtask

  initial begin
    bus.PushCoef   = 1'b0;
    bus.CoefAddr   = 5'd0;
    bus.CoefI      = '0;
    bus.CoefQ      = '0;
    bus.CoefCommit = 1'b0;

    // Full load 0..14, swap edge, quiet edge, two bad addresses, quiet edge.
    for (int i = 0; i < 20; i++) begin
      tbl[i] = '{push: 1'b0, addr: 5'd0, ci: '0, cq: '0, commit: 1'b0, idle: 1'b1, cs: 1'b0,
                 e_hold: 1'b0, e_pend: 1'b0, e_swap: 1'b0, e_err: 1'b0, e_ver: 8'd1};
    end
    for (int i = 0; i < NCOEF; i++) begin
      tbl[i].push   = 1'b1;
      tbl[i].addr   = 5'(i);
      tbl[i].ci     = cv(i + 1);
      tbl[i].cq     = cv(-(i + 1));
      tbl[i].e_pend = 1'b1;
      tbl[i].e_hold = (i == NCOEF - 1);
      tbl[i].e_ver  = 8'd0;
    end
    tbl[15].e_swap = 1'b1;
    tbl[17].push   = 1'b1;
    tbl[17].addr   = 5'd15;
    tbl[17].e_err  = 1'b1;
    tbl[18].push   = 1'b1;
    tbl[18].addr   = 5'd31;
    tbl[18].e_err  = 1'b1;

    // Reset state
    for (int k = 0; k < NCOEF; k++) exp_act[k] = '0;
    Reset = 1'b1;
    cyc(1'b0, 5'd0, '0, '0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 5'd0, '0, '0, 1'b0, 1'b1, 1'b0);
    chk_out("reset", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    chk_bank("reset_bank");
    Reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      cyc(tbl[i].push, tbl[i].addr, tbl[i].ci, tbl[i].cq, tbl[i].commit, tbl[i].idle, tbl[i].cs);
      chk_out($sformatf("vec%0d", i), tbl[i].e_hold, tbl[i].e_pend, tbl[i].e_swap,
              tbl[i].e_err, tbl[i].e_ver);
    end
    for (int k = 0; k < NCOEF; k++) exp_act[k] = {cv(k + 1), cv(-(k + 1))};
    chk_bank("full_load_bank");
    chk("entry14", 64'(ent(14)), 64'({cv(15), cv(-15)}));

    // Partial commit held off by a busy datapath, then a calc_start collision.
    cyc(1'b1, 5'd3, cv(100), cv(-4), 1'b0, 1'b0, 1'b0);
    chk_out("pc_write", 1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
    cyc(1'b0, 5'd0, '0, '0, 1'b1, 1'b0, 1'b0);
    chk_out("pc_commit", 1'b1, 1'b1, 1'b0, 1'b0, 8'd1);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 5'd0, '0, '0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("defer_hold%0d", i), 64'(hold_start), 64'd1);
      chk_bank($sformatf("defer_bank%0d", i));
    end
    cyc(1'b0, 5'd0, '0, '0, 1'b0, 1'b1, 1'b1);
    chk_out("defer_cs", 1'b1, 1'b1, 1'b0, 1'b0, 8'd1);
    chk_bank("defer_cs_bank");
    cyc(1'b0, 5'd0, '0, '0, 1'b0, 1'b1, 1'b0);
    exp_act[3] = {cv(100), cv(-4)};
    chk_out("pc_swap", 1'b0, 1'b0, 1'b1, 1'b0, 8'd2);
    chk_bank("pc_bank");
    cyc(1'b0, 5'd0, '0, '0, 1'b0, 1'b1, 1'b0);
    chk("pc_swap_once", 64'(coef_swap), 64'd0);

    // Write to address 7 on the very swap edge.
    cyc(1'b1, 5'd0, cv(500), cv(501), 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 5'd0, '0, '0, 1'b1, 1'b0, 1'b0);
    chk("sim_ready", 64'(hold_start), 64'd1);
    cyc(1'b1, 5'd7, cv(777), cv(0), 1'b0, 1'b1, 1'b0);
    exp_act[0] = {cv(500), cv(501)};
    chk_out("sim_swap", 1'b0, 1'b1, 1'b1, 1'b0, 8'd3);
    chk_bank("sim_bank");
    // Only bit 7 may be set: the remaining 14 writes are needed to reach READY.
    for (int k = 0; k < NCOEF; k++) begin
      if (k != 7) begin
        cyc(1'b1, 5'(k), cv(k + 1), cv(-(k + 1)), 1'b0, 1'b0, 1'b0);
        chk($sformatf("sim_fill_hold%0d", k), 64'(hold_start), 64'(k == NCOEF - 1));
      end
    end
    cyc(1'b0, 5'd0, '0, '0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < NCOEF; k++) exp_act[k] = {cv(k + 1), cv(-(k + 1))};
    exp_act[7] = {cv(777), cv(0)};
    chk_out("sim_swap2", 1'b0, 1'b0, 1'b1, 1'b0, 8'd4);
    chk_bank("sim_bank2");

    // Version wrap: swaps 5..256.
    for (int n = 5; n <= 256; n++) begin
      cyc(1'b1, 5'd0, cv(1), cv(-1), 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 5'd0, '0, '0, 1'b1, 1'b1, 1'b0);
      cyc(1'b0, 5'd0, '0, '0, 1'b0, 1'b1, 1'b0);
      if (n == 255) chk("wrap_255", 64'(coef_version), 64'd255);
    end
    chk("wrap_zero", 64'(coef_version), 64'd0);
    chk("wrap_swap", 64'(coef_swap), 64'd1);
    chk_bank("wrap_bank");

    // Reset with mask bits 0..9 set.
    for (int k = 0; k < 10; k++) cyc(1'b1, 5'(k), cv(9), cv(9), 1'b0, 1'b0, 1'b0);
    Reset = 1'b1;
    cyc(1'b0, 5'd0, '0, '0, 1'b0, 1'b0, 1'b0);
    Reset = 1'b0;
    for (int k = 0; k < NCOEF; k++) exp_act[k] = '0;
    chk_out("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    chk_bank("rst_mid_bank");
    cyc(1'b1, 5'd10, cv(3), cv(3), 1'b0, 1'b0, 1'b0);
    chk_out("rst_first", 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    cyc(1'b1, 5'd20, cv(3), cv(3), 1'b0, 1'b0, 1'b0);
    chk_out("rst_err", 1'b0, 1'b1, 1'b0, 1'b1, 8'd0);
    for (int k = 11; k < NCOEF; k++) begin
      cyc(1'b1, 5'(k), cv(3), cv(3), 1'b0, 1'b0, 1'b0);
      chk($sformatf("rst_load_hold%0d", k), 64'(hold_start), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/coef_bank_ctrl.md
# coef_bank_ctrl

Double-buffered coefficient bank controller for the complex 29-tap symmetric FIR. It accepts coefficient writes into a shadow bank and transfers the whole bank to the active bank that feeds the datapath. The transfer happens only at a computation boundary, so no output sample is ever computed with a mix of old and new coefficients. It sits between the coefficient write port of `firc` and `fir_datapath`, and takes its boundary information from `control_fsm`.

## Interface
- `NCOEF`, default 15: stored complex coefficients (14 mirrored taps plus the centre tap at index 14).
- `CW`, default 27: width of each I or Q coefficient (signed, 3.24).
- `VW`, default 8: width of the bank version counter.
- `clk` in 1: single clock; all state updates on its rising edge.
- `Reset` in 1: synchronous, active-high; sampled on the rising edge of `clk`.
- `PushCoef` in 1: coefficient write strobe.
- `CoefAddr` in 5: write index; 0..NCOEF-1 are valid.
- `CoefI` in CW: signed real part of the written coefficient.
- `CoefQ` in CW: signed imaginary part of the written coefficient.
- `CoefCommit` in 1: forces a partially written shadow bank to be marked ready.
- `mult_idle` in 1: from `control_fsm`; the datapath is not in the middle of a computation.
- `calc_start` in 1: from `control_fsm`; a new computation starts on this edge (the FIFO pull).
- `coef_active` out NCOEF*2*CW: flattened active bank. Entry k occupies bits [k*2*CW +: 2*CW], with I in the upper CW bits and Q in the lower CW bits.
- `hold_start` out 1: asks `control_fsm` not to start a new computation.
- `coef_pending` out 1: the shadow bank holds uncommitted writes.
- `coef_swap` out 1: one-cycle pulse reporting that the active bank has just been replaced.
- `coef_version` out VW: count of completed swaps; wraps from 2^VW-1 to 0.
- `coef_addr_err` out 1: one-cycle pulse reporting a write to an out-of-range address.

## Operation
- Storage:
  - The shadow bank is NCOEF×(I,Q) registers.
  - The active bank is NCOEF×(I,Q) registers.
  - `wr_mask` holds one written-flag per entry (NCOEF bits).
- Write (`PushCoef`=1 with `CoefAddr` < NCOEF):
  - shadow[CoefAddr] is loaded with {CoefI, CoefQ}.
  - `wr_mask[CoefAddr]` is set.
  - Rewriting an already-written address overwrites the value; the mask bit stays set.
- Out-of-range write (`PushCoef`=1 with `CoefAddr` ≥ NCOEF):
  - No storage or mask change.
  - `coef_addr_err` pulses for one cycle.
- State machine, 3 states:
  - IDLE: `wr_mask`=0. A valid write goes to LOAD.
  - LOAD: at least one mask bit is set. Goes to READY when `wr_mask` becomes all-ones, or on `CoefCommit`=1. Unwritten entries keep their previous shadow values.
  - READY: waits for a boundary. A swap occurs on an edge where `mult_idle`=1 and `calc_start`=0. Writes during READY update the shadow bank and the state remains READY.
  - `CoefCommit` in IDLE is ignored.
- Swap edge:
  - The active bank is loaded from the shadow bank as it stood before that edge.
  - `wr_mask` is cleared.
  - `coef_version` increments.
  - The state goes to IDLE.
  - A valid write on the same edge lands in the shadow bank after the copy. It sets only its own mask bit, and the state goes to LOAD instead of IDLE.
- The shadow bank is never cleared except by reset, so a later partial update plus `CoefCommit` modifies only the rewritten entries.
- `hold_start` = (state == READY). `control_fsm` suppresses `calc_start` while it is high, so the swap happens at the first idle cycle and cannot deadlock.
- `coef_pending` = (state != IDLE).

## Timing
- Reset values of all outputs:
  - `coef_active` = 0.
  - `coef_version` = 0.
  - `coef_swap`, `coef_addr_err`, `hold_start`, `coef_pending` = 0.
- Internal state at reset: shadow = 0, `wr_mask` = 0, state = IDLE.
- Reset mid-operation discards pending writes and the READY status on the same edge.
- Write latency: a write on edge N sets the shadow entry and the mask at edge N. A completing write at N puts the state in READY after N, so `hold_start` is high in cycle N+1.
- Swap edge M:
  - `coef_active` shows the new bank in cycle M+1.
  - `coef_swap`=1 in cycle M+1 only.
  - `coef_version` is updated in cycle M+1.
- Earliest swap: with `mult_idle`=1 throughout, the swap occurs one edge after entry to READY.
- If `calc_start`=1 coincides with the READY condition, the swap is deferred. The computation started on that edge uses the old bank, and the swap follows the next qualifying idle edge.
- `coef_addr_err` is registered: asserted in the cycle after the offending edge.
- `coef_active` is a pure register output and changes only on swap edges or reset.

## Test plan
- **Full load:** after reset, write addresses 0..14 with I=k+1, Q=-(k+1), keeping `mult_idle`=1.
  - READY after the address-14 write.
  - One edge later, entry 14 of `coef_active` holds I=15, Q=-15.
  - `coef_swap` pulses once and `coef_version`=1.
- **Boundary deferral:** complete a load while `mult_idle`=0 for 20 cycles.
  - `hold_start`=1 and `coef_active` unchanged for the full 20 cycles.
  - The swap occurs on the first edge with `mult_idle`=1 and `calc_start`=0.
- **Partial commit:** after the full load, write only address 3 with I=100, then pulse `CoefCommit`.
  - After the swap, entry 3 = 100 and all other entries are unchanged.
  - `coef_version`=2.
- **Simultaneous write and swap:** write address 7 on the exact swap edge.
  - The active bank does not contain the new value for address 7.
  - Afterwards the state is LOAD with only mask bit 7 set, and `coef_pending`=1.
- **Error and wrap:** write `CoefAddr`=15 and 31.
  - `coef_addr_err` pulses twice; no state change.
  - Separately, 256 swaps bring `coef_version` back to 0.
- **Reset mid-load:** assert `Reset` with mask bits 0..9 set.
  - All outputs 0 on the next cycle.
  - The next single write leaves the state in LOAD, not READY.
